// File: rtl/spi_master_ctrl.sv
// SPI initiator for the SPI slave / single-port-RAM wrapper.
// One serial bit per clk; frame = {cmd[1:0], data[DATA_W-1:0]} sent MSB first,
// preceded by a select cycle and a mode cycle. rd-data frames (cmd 11) then
// wait TURNAROUND cycles and clock DATA_W bits back in on MISO.
module spi_master_ctrl #(
   parameter int DATA_W     = 8,
   parameter int TURNAROUND = 2,
   parameter int GAP        = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_cmd,
   input  logic [DATA_W-1:0] req_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   localparam int FW   = DATA_W + 2;
   localparam int CMAX = (FW > TURNAROUND) ? ((FW > GAP) ? FW : GAP)
                                           : ((TURNAROUND > GAP) ? TURNAROUND : GAP);
   localparam int CW   = $clog2(CMAX + 1);

   typedef struct packed {
      logic [1:0]        cmd;
      logic [DATA_W-1:0] data;
   } frame_t;

   typedef enum logic [2:0] {IDLE, SETUP, MODE, SHIFT, TURN, READ, GAP_ST} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   frame_t            word;
   logic [DATA_W-1:0] sh;
   logic              accept;
   logic              rd_done;
   logic              ss_n_nxt;
   logic              mosi_nxt;

   // Ready is withheld while reset is asserted so a request can never be taken then.
   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign busy      = (state != IDLE);

   // Next-state, phase counter and the pin values for the coming cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rd_done   = 1'b0;
      case (state)
         IDLE:  if (accept) state_nxt = SETUP;
         SETUP: state_nxt = MODE;
         MODE: begin
            state_nxt = SHIFT;
            cnt_nxt   = CW'(FW - 1);
         end
         SHIFT: begin
            if (cnt == '0) begin
               if (word.cmd == 2'b11) begin
                  state_nxt = TURN;
                  cnt_nxt   = CW'(TURNAROUND - 1);
               end else begin
                  state_nxt = GAP_ST;
                  cnt_nxt   = CW'(GAP - 1);
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         TURN: begin
            if (cnt == '0) begin
               state_nxt = READ;
               cnt_nxt   = CW'(DATA_W - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         READ: begin
            if (cnt == '0) begin
               rd_done   = 1'b1;
               state_nxt = GAP_ST;
               cnt_nxt   = CW'(GAP - 1);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         GAP_ST: begin
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - CW'(1);
         end
         default: state_nxt = IDLE;
      endcase

      // Pins are registered, so they are derived from the state being entered.
      ss_n_nxt = !(state_nxt inside {SETUP, MODE, SHIFT, TURN, READ});
      mosi_nxt = 1'b0;
      if (state_nxt == MODE)       mosi_nxt = word[FW-1];
      else if (state_nxt == SHIFT) mosi_nxt = word[cnt_nxt];
   end

   // State, latched command word, MISO capture and registered pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         word     <= '0;
         sh       <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         SS_n     <= 1'b1;
         MOSI     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         SS_n     <= ss_n_nxt;
         MOSI     <= mosi_nxt;
         rd_valid <= rd_done;
         if (accept) word <= {req_cmd, req_data};
         // Capture into a side register so rd_data only changes on a completed read.
         if (state == READ) sh <= {sh[DATA_W-2:0], MISO};
         if (rd_done) rd_data <= {sh[DATA_W-2:0], MISO};
      end
   end

endmodule
